shift_sub_divider: RTL and testbench

Sequential restoring divider (shift-and-subtract) that produces an unsigned quotient and remainder one bit per clock. It is the inverse companion to the shift-and-add multiplier in the Multiply arithmetic group and shares that unit's Start/Done handshake, so both can sit behind the same control sequencer. It takes a 16-bit dividend and an 8-bit divisor, and returns a 16-bit quotient and an 8-bit remainder.

---
 rtl/shift_sub_divider.sv | 112 +++++++++++
 tb/tb_shift_sub_divider.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/shift_sub_divider.sv
// Sequential restoring (shift-and-subtract) unsigned divider, one quotient bit per clock.
// Shares the Start/Done handshake of the shift-and-add multiplier.
//
// state | meaning
// IDLE  | waiting for Start; last result held on Quotient/Remainder
// WORK  | one shift/subtract iteration per cycle, DVD_W iterations
// DONE  | result presented with Done=1 until Start is low

module shift_sub_divider #(
  parameter int DVD_W = 16,
  parameter int DVS_W = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [DVD_W-1:0] Dividend,
  input  logic [DVS_W-1:0] Divisor,
  output logic [DVD_W-1:0] Quotient,
  output logic [DVS_W-1:0] Remainder,
  output logic             Done,
  output logic             DivByZero
);

  localparam int CNT_W = $clog2(DVD_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DVD_W);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WORK = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state;
  logic [DVD_W-1:0] dvd_sr;   // dividend shifts out the top, quotient bits shift in the bottom
  logic [DVS_W-1:0] dvs_r;
  logic [DVS_W:0]   prem;
  logic [CNT_W-1:0] count;

  // One extra bit above the partial remainder so the borrow of the trial shows up as its MSB.
  logic [DVS_W+1:0] shifted;
  logic [DVS_W+1:0] trial;
  logic             trial_neg;

  always_comb begin
    shifted   = {prem, dvd_sr[DVD_W-1]};
    trial     = shifted - {2'b00, dvs_r};
    trial_neg = trial[DVS_W+1];
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      count     <= '0;
      dvd_sr    <= '0;
      dvs_r     <= '0;
      prem      <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            if (Divisor != '0) begin
              dvd_sr <= Dividend;
              dvs_r  <= Divisor;
              prem   <= '0;
              count  <= '0;
              state  <= WORK;
            end else begin
              Quotient  <= '1;
              Remainder <= '0;
              DivByZero <= 1'b1;
              Done      <= 1'b1;
              state     <= DONE;
            end
          end
        end
        WORK: begin
          if (count == LAST) begin
            Quotient  <= dvd_sr;
            Remainder <= prem[DVS_W-1:0];
            Done      <= 1'b1;
            DivByZero <= 1'b0;
            state     <= DONE;
          end else begin
            prem   <= trial_neg ? shifted[DVS_W:0] : trial[DVS_W:0];
            dvd_sr <= {dvd_sr[DVD_W-2:0], ~trial_neg};
            count  <= count + 1'b1;
          end
        end
        DONE: begin
          if (!Start) begin
            Done      <= 1'b0;
            DivByZero <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          count     <= '0;
          Quotient  <= '0;
          Remainder <= '0;
          Done      <= 1'b0;
          DivByZero <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sub_divider.sv
// Self-checking bench for shift_sub_divider: directed cases plus a random sweep
// compared against plain integer division.

module tb_shift_sub_divider;

  logic        Clock;
  logic        Reset;
  logic        Start;
  logic [15:0] Dividend;
  logic [7:0]  Divisor;
  logic [15:0] Quotient;
  logic [7:0]  Remainder;
  logic        Done;
  logic        DivByZero;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] prev_q = '0;
  logic [7:0]  prev_r = '0;

  shift_sub_divider #(.DVD_W(16), .DVS_W(8)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .Start(Start),
    .Dividend(Dividend),
    .Divisor(Divisor),
    .Quotient(Quotient),
    .Remainder(Remainder),
    .Done(Done),
    .DivByZero(DivByZero)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Issues one operation; cycle count includes the accepting edge.
  task automatic run_op(input logic [15:0] a, input logic [7:0] b, input bit hold);
    int cyc;
    logic [15:0] eq;
    logic [7:0]  er;
    if (b == 8'd0) begin
      eq = 16'hFFFF;
      er = 8'd0;
    end else begin
      eq = a / 16'(b);
      er = 8'(a % 16'(b));
    end
    Dividend = a;
    Divisor  = b;
    Start    = 1'b1;
    tick();
    cyc = 1;
    if (!hold) Start = 1'b0;
    Dividend = 16'($urandom);
    Divisor  = 8'($urandom);
    while (!Done && cyc < 40) begin
      if (cyc == 4) begin
        check("q_hold_work", 32'(Quotient), 32'(prev_q));
        check("r_hold_work", 32'(Remainder), 32'(prev_r));
      end
      tick();
      cyc++;
    end
    check("latency", 32'(cyc), (b == 8'd0) ? 32'd1 : 32'd18);
    check("quotient", 32'(Quotient), 32'(eq));
    check("remainder", 32'(Remainder), 32'(er));
    check("divbyzero", 32'(DivByZero), (b == 8'd0) ? 32'd1 : 32'd0);
    if (b != 8'd0 && Done) begin
      check("invariant", 32'(Quotient) * 32'(b) + 32'(Remainder), 32'(a));
      check("rem_lt_div", 32'(Remainder < b), 32'd1);
    end
    if (hold) begin
      repeat (3) begin
        tick();
        check("hold_done", 32'(Done), 32'd1);
        check("hold_q", 32'(Quotient), 32'(eq));
      end
      Start = 1'b0;
    end
    tick();
    check("done_clr", 32'(Done), 32'd0);
    check("dbz_clr", 32'(DivByZero), 32'd0);
    check("q_keep_idle", 32'(Quotient), 32'(eq));
    prev_q = eq;
    prev_r = er;
  endtask

  initial begin
    Reset    = 1'b1;
    Start    = 1'b0;
    Dividend = '0;
    Divisor  = '0;
    repeat (2) tick();
    check("rst_q", 32'(Quotient), 32'd0);
    check("rst_r", 32'(Remainder), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_dbz", 32'(DivByZero), 32'd0);
    Reset = 1'b0;
    tick();

    run_op(16'd1000, 8'd7, 1'b0);
    run_op(16'd65535, 8'd255, 1'b0);
    run_op(16'd65535, 8'd1, 1'b0);
    run_op(16'd5, 8'd9, 1'b0);
    run_op(16'd0, 8'd3, 1'b0);
    run_op(16'd1234, 8'd0, 1'b0);
    run_op(16'd300, 8'd16, 1'b1);

    // Start held low after DONE: no second result appears.
    repeat (3) begin
      tick();
      check("no_retrigger", 32'(Done), 32'd0);
    end

    // Reset in the middle of WORK.
    Dividend = 16'd1000;
    Divisor  = 8'd7;
    Start    = 1'b1;
    tick();
    Start = 1'b0;
    repeat (8) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("midrst_q", 32'(Quotient), 32'd0);
    check("midrst_r", 32'(Remainder), 32'd0);
    check("midrst_done", 32'(Done), 32'd0);
    check("midrst_dbz", 32'(DivByZero), 32'd0);
    prev_q = '0;
    prev_r = '0;
    repeat (20) tick();
    check("midrst_idle", 32'(Done), 32'd0);
    run_op(16'd100, 8'd10, 1'b0);

    for (int i = 0; i < 2000; i++) begin
      run_op(16'($urandom), 8'($urandom_range(0, 255)), bit'($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
